// File: rtl/frame_sched_ctrl.sv
// rtl/frame_sched_ctrl.sv - frame request scheduler and frame/line timing monitor
module frame_sched_ctrl #(
    parameter int EXP_LINES     = 180,
    parameter int EXP_PIXELS    = 240,
    parameter int START_TIMEOUT = 1048576,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      cfg_frames,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             gen_frame_valid,
    input  logic             gen_line_valid,
    output logic             gen_frame_req,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frames_sent,
    output logic [11:0]      last_lines,
    output logic             err_geom,
    output logic             err_overrun,
    output logic             err_timeout
);
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_REQ         = 3'd1;
    localparam logic [2:0] ST_WAIT_FV     = 3'd2;
    localparam logic [2:0] ST_IN_FRAME    = 3'd3;
    localparam logic [2:0] ST_WAIT_PERIOD = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // The request cycle itself counts toward the start timeout.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] EXP_PIX  = CNT_W'(EXP_PIXELS);
    localparam logic [11:0]      EXP_LN   = 12'(EXP_LINES);

    logic [2:0]       state;
    logic             fv_q, lv_q, stop_pending;
    logic [CNT_W-1:0] period_cnt, tmo_cnt, pix_cnt, period_lat;
    logic [11:0]      line_cnt;
    logic [15:0]      frames_tgt;
    logic             fv_rise, fv_fall, lv_rise, lv_fall;
    logic             b2b, overrun_now, req_due, last_frame, stop_req;

    assign fv_rise = gen_frame_valid & ~fv_q;
    assign fv_fall = ~gen_frame_valid & fv_q;
    assign lv_rise = gen_line_valid & ~lv_q;
    assign lv_fall = ~gen_line_valid & lv_q;

    // period_cnt lags the elapsed cycle count since the request by one, so the
    // next request is due one cycle after it reaches cfg_period-2.
    assign b2b         = period_lat <= CNT_W'(1);
    assign overrun_now = b2b || (period_cnt >= period_lat - CNT_W'(1));
    assign req_due     = b2b || (period_cnt >= period_lat - CNT_W'(2));
    assign last_frame  = (frames_tgt != 16'd0) && (frames_sent + 16'd1 == frames_tgt);
    assign stop_req    = stop | stop_pending;

    assign gen_frame_req = (state == ST_REQ);
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            fv_q         <= 1'b0;
            lv_q         <= 1'b0;
            stop_pending <= 1'b0;
            period_cnt   <= '0;
            tmo_cnt      <= '0;
            pix_cnt      <= '0;
            period_lat   <= '0;
            line_cnt     <= 12'd0;
            frames_tgt   <= 16'd0;
            frame_done   <= 1'b0;
            frames_sent  <= 16'd0;
            last_lines   <= 12'd0;
            err_geom     <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            fv_q       <= gen_frame_valid;
            lv_q       <= gen_line_valid;
            frame_done <= 1'b0;
            if (state != ST_IDLE && state != ST_REQ && period_cnt != CNT_MAX)
                period_cnt <= period_cnt + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        frames_sent <= 16'd0;
                        err_geom    <= 1'b0;
                        err_overrun <= 1'b0;
                        err_timeout <= 1'b0;
                        frames_tgt  <= cfg_frames;
                        period_lat  <= cfg_period;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    period_cnt <= '0;
                    tmo_cnt    <= '0;
                    if (stop) stop_pending <= 1'b1;
                    state <= ST_WAIT_FV;
                end
                ST_WAIT_FV: begin
                    if (stop) stop_pending <= 1'b1;
                    if (fv_rise) begin
                        line_cnt <= {11'd0, lv_rise};
                        pix_cnt  <= CNT_W'(gen_line_valid);
                        state    <= ST_IN_FRAME;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout  <= 1'b1;
                        stop_pending <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_IN_FRAME: begin
                    if (stop) stop_pending <= 1'b1;
                    if (lv_rise && gen_frame_valid) line_cnt <= line_cnt + 12'd1;
                    if (lv_fall) begin
                        pix_cnt <= '0;
                        if (pix_cnt != EXP_PIX) err_geom <= 1'b1;
                    end else if (gen_line_valid) begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                    end
                    if (fv_fall) begin
                        frame_done  <= 1'b1;
                        frames_sent <= frames_sent + 16'd1;
                        last_lines  <= line_cnt;
                        if (line_cnt != EXP_LN) err_geom <= 1'b1;
                        if (overrun_now) err_overrun <= 1'b1;
                        if (stop_req || last_frame) begin
                            stop_pending <= 1'b0;
                            state        <= ST_IDLE;
                        end else if (req_due) begin
                            state <= ST_REQ;
                        end else begin
                            state <= ST_WAIT_PERIOD;
                        end
                    end
                end
                ST_WAIT_PERIOD: begin
                    if (stop_req) begin
                        stop_pending <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (req_due) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_sched_ctrl.sv
// tb/tb_frame_sched_ctrl.sv - self-checking bench for frame_sched_ctrl
module tb_frame_sched_ctrl;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   cfg_frames = 16'd0;
    logic [CW-1:0] cfg_period = '0;
    logic          gen_frame_valid, gen_line_valid;
    logic          gen_frame_req, busy, frame_done, err_geom, err_overrun, err_timeout;
    logic [15:0]   frames_sent;
    logic [11:0]   last_lines;

    frame_sched_ctrl #(
        .EXP_LINES(4), .EXP_PIXELS(8), .START_TIMEOUT(64), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .cfg_frames(cfg_frames), .cfg_period(cfg_period),
        .gen_frame_valid(gen_frame_valid), .gen_line_valid(gen_line_valid),
        .gen_frame_req(gen_frame_req), .busy(busy), .frame_done(frame_done),
        .frames_sent(frames_sent), .last_lines(last_lines),
        .err_geom(err_geom), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int frames, period, lines, pix, tail;
        int exp_last;
        bit exp_geom, exp_ovr;
    } vec_t;

    int n_checks = 0, n_fail = 0, n_done = 0, cyc = 0, idle_cyc = 0;
    int req_q[$], fall_q[$], lines_q[$], pix_q[$];
    bit gm_on = 1'b1, gm_rand = 1'b0, gm_busy = 1'b0;
    int gm_lines = 4, gm_pix = 8, gm_tail = 2, gm_lead = 2, gm_short_abs = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gen_frame_req) req_q.push_back(cyc);
        if (frame_done) n_done <= n_done + 1;
    end

    // Generator model: answers each request with a frame; fall cycle recorded per frame.
    initial begin : generator
        int nl, np, tl, ld;
        gen_frame_valid = 1'b0;
        gen_line_valid  = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_frame_req && gm_on && reset_n) begin
                gm_busy = 1'b1;
                nl = gm_lines; np = gm_pix; tl = gm_tail; ld = gm_lead;
                if (gm_rand) begin
                    nl = int'($urandom_range(5, 3));
                    np = int'($urandom_range(9, 7));
                    tl = int'($urandom_range(60, 1));
                    ld = int'($urandom_range(6, 1));
                end
                if (fall_q.size() == gm_short_abs) nl = 3;
                repeat (ld) @(negedge clk);
                gen_frame_valid = 1'b1;
                repeat (2) @(negedge clk);
                for (int l = 0; l < nl; l++) begin
                    gen_line_valid = 1'b1;
                    repeat (np) @(negedge clk);
                    gen_line_valid = 1'b0;
                    repeat (2) @(negedge clk);
                end
                repeat (tl) @(negedge clk);
                gen_frame_valid = 1'b0;
                fall_q.push_back(cyc);
                lines_q.push_back(nl);
                pix_q.push_back(np);
                gm_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int frames, input int period, input bit with_stop);
        @(negedge clk);
        cfg_frames = 16'(frames);
        cfg_period = CW'(period);
        start = 1'b1;
        stop  = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 0);
        idle_cyc = cyc;
        #2;
    endtask

    // Requests are spaced max(period, fall offset + 1); the controller goes idle the cycle after the last fall.
    task automatic verify_run(input string name, input int frames, input int period, input int exp_last,
                              input bit exp_geom, input bit exp_ovr, input int rb, input int fb, input int db);
        int k;
        check({name, "_sent"}, frames_sent, frames);
        check({name, "_last_lines"}, last_lines, exp_last);
        check({name, "_geom"}, err_geom, exp_geom);
        check({name, "_overrun"}, err_overrun, exp_ovr);
        check({name, "_timeout"}, err_timeout, 0);
        check({name, "_done_pulses"}, n_done - db, frames);
        check({name, "_reqs"}, req_q.size() - rb, frames);
        for (int i = 1; i < frames && rb + i < req_q.size() && fb + i - 1 < fall_q.size(); i++) begin
            k = fall_q[fb + i - 1] - req_q[rb + i - 1];
            check($sformatf("%s_gap%0d", name, i), req_q[rb + i] - req_q[rb + i - 1],
                  (k + 1 > period) ? k + 1 : period);
        end
        if (fall_q.size() > fb) check({name, "_idle_cycle"}, idle_cyc, fall_q[fall_q.size() - 1] + 1);
    endtask

    initial begin : main
        vec_t vecs[7];
        int rb, fb, db, n, f, p;
        bit eg, eo;

        vecs[0] = '{3, 200, 4, 8, 2, 4, 1'b0, 1'b0};
        vecs[1] = '{2, 50, 4, 8, 36, 4, 1'b0, 1'b1};
        vecs[2] = '{2, 200, 4, 7, 2, 4, 1'b1, 1'b0};
        vecs[3] = '{2, 200, 5, 8, 2, 5, 1'b1, 1'b0};
        vecs[4] = '{2, 0, 4, 8, 2, 4, 1'b0, 1'b1};
        vecs[5] = '{3, 1, 4, 8, 2, 4, 1'b0, 1'b1};
        vecs[6] = '{1, 200, 4, 8, 2, 4, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_flags", {26'd0, gen_frame_req, busy, frame_done, err_geom, err_overrun, err_timeout}, 0);
        check("rst_frames_sent", frames_sent, 0);
        check("rst_last_lines", last_lines, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            gm_lines = vecs[i].lines; gm_pix = vecs[i].pix; gm_tail = vecs[i].tail;
            rb = req_q.size(); fb = fall_q.size(); db = n_done;
            pulse_start(vecs[i].frames, vecs[i].period, 1'b0);
            wait_idle($sformatf("vec%0d", i), 3000);
            verify_run($sformatf("vec%0d", i), vecs[i].frames, vecs[i].period, vecs[i].exp_last,
                       vecs[i].exp_geom, vecs[i].exp_ovr, rb, fb, db);
        end
        gm_lines = 4; gm_pix = 8; gm_tail = 2;

        // Continuous run, ignored restart while busy, stop during frame 5.
        rb = req_q.size(); fb = fall_q.size(); db = n_done;
        pulse_start(0, 200, 1'b0);
        n = 0;
        while (fall_q.size() < fb + 2 && n < 3000) begin @(negedge clk); n++; end
        pulse_start(1, 50, 1'b0);
        n = 0;
        while (!(fall_q.size() == fb + 4 && gen_line_valid) && n < 3000) begin @(negedge clk); n++; end
        check("stop_reach_frame5", fall_q.size() - fb, 4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("stop", 3000);
        verify_run("stop", 5, 200, 4, 1'b0, 1'b0, rb, fb, db);
        repeat (300) @(negedge clk);
        check("stop_no_6th_req", req_q.size() - rb, 5);

        // Short frame 2 of 3, then a restart clears err_geom.
        rb = req_q.size(); fb = fall_q.size(); db = n_done;
        gm_short_abs = fb + 1;
        pulse_start(3, 200, 1'b0);
        n = 0;
        while (n_done - db < 2 && n < 3000) begin @(negedge clk); n++; end
        #2;
        check("geom_f2_flag", err_geom, 1);
        check("geom_f2_last_lines", last_lines, 3);
        check("geom_f2_busy", busy, 1);
        wait_idle("geom", 3000);
        verify_run("geom", 3, 200, 4, 1'b1, 1'b0, rb, fb, db);
        gm_short_abs = -1;
        rb = req_q.size(); fb = fall_q.size(); db = n_done;
        pulse_start(1, 200, 1'b0);
        check("geom_cleared_on_start", err_geom, 0);
        wait_idle("geom_clean", 3000);
        verify_run("geom_clean", 1, 200, 4, 1'b0, 1'b0, rb, fb, db);

        // Generator ignores the request.
        gm_on = 1'b0;
        rb = req_q.size();
        pulse_start(2, 200, 1'b0);
        n = 0;
        while (!err_timeout && n < 200) begin @(negedge clk); n++; end
        check("tmo_flag", err_timeout, 1);
        check("tmo_reqs", req_q.size() - rb, 1);
        if (req_q.size() > rb) check("tmo_latency", cyc - req_q[rb], 64);
        check("tmo_busy", busy, 0);
        check("tmo_sent", frames_sent, 0);
        gm_on = 1'b1;

        // start and stop together in IDLE.
        rb = req_q.size();
        pulse_start(0, 200, 1'b1);
        repeat (10) @(negedge clk);
        check("start_stop_reqs", req_q.size() - rb, 0);
        check("start_stop_busy", busy, 0);

        // Asynchronous reset in the middle of frame 2.
        fb = fall_q.size();
        pulse_start(0, 200, 1'b0);
        n = 0;
        while (!(fall_q.size() == fb + 1 && gen_line_valid) && n < 3000) begin @(negedge clk); n++; end
        check("rstm_pre_sent", frames_sent, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rstm_flags", {26'd0, gen_frame_req, busy, frame_done, err_geom, err_overrun, err_timeout}, 0);
        check("rstm_frames_sent", frames_sent, 0);
        check("rstm_last_lines", last_lines, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (gm_busy && n < 3000) begin @(negedge clk); n++; end
        check("rstm_gen_idle", gm_busy, 0);
        rb = req_q.size(); fb = fall_q.size(); db = n_done;
        pulse_start(2, 200, 1'b0);
        wait_idle("fresh", 3000);
        verify_run("fresh", 2, 200, 4, 1'b0, 1'b0, rb, fb, db);

        // Randomized schedules against the rule-level model.
        gm_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            f = int'($urandom_range(4, 1));
            p = int'($urandom_range(150, 0));
            rb = req_q.size(); fb = fall_q.size(); db = n_done;
            pulse_start(f, p, 1'b0);
            wait_idle($sformatf("rnd%0d", it), 4000);
            eg = 1'b0; eo = 1'b0;
            for (int j = 0; j < f && fb + j < fall_q.size() && rb + j < req_q.size(); j++) begin
                if (lines_q[fb + j] != 4 || pix_q[fb + j] != 8) eg = 1'b1;
                if (fall_q[fb + j] - req_q[rb + j] >= p) eo = 1'b1;
            end
            verify_run($sformatf("rnd%0d", it), f, p,
                       (lines_q.size() > 0) ? lines_q[lines_q.size() - 1] : 0, eg, eo, rb, fb, db);
        end
        gm_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
